// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipeline-stage skid register.
//   state_e   : stage occupancy state (EMPTY / HALF / FULL)
//   INST_NOP  : all-zero NOP word, the usual bubble payload for IF/ID stages
//   occ_of()  : maps a stage state onto its held-entry count
// ---------------------------------------------------------------------------
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HALF  = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    localparam logic [31:0] INST_NOP = 32'h0000_0000;

    // Number of entries held in a given state.
    function automatic logic [1:0] occ_of(input state_e s);
        logic [1:0] occ;
        case (s)
            ST_EMPTY: occ = 2'd0;
            ST_HALF:  occ = 2'd1;
            ST_FULL:  occ = 2'd2;
            default:  occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid_if
// Handshake bundle around one pipeline stage boundary.
//   up_valid/up_ready/up_pc/up_data : upstream producer side
//   dn_valid/dn_ready/dn_pc/dn_data : downstream consumer side
// Modports:
//   master : the environment (drives up_* offers and dn_ready)
//   slave  : the stage itself (drives up_ready and dn_* outputs)
// ---------------------------------------------------------------------------
interface pipe_stage_skid_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              up_valid;
    logic              up_ready;
    logic [ADDR_W-1:0] up_pc;
    logic [DATA_W-1:0] up_data;
    logic              dn_valid;
    logic              dn_ready;
    logic [ADDR_W-1:0] dn_pc;
    logic [DATA_W-1:0] dn_data;

    modport master (
        output up_valid, up_pc, up_data, dn_ready,
        input  up_ready, dn_valid, dn_pc, dn_data
    );

    modport slave (
        input  up_valid, up_pc, up_data, dn_ready,
        output up_ready, dn_valid, dn_pc, dn_data
    );
endinterface

// File: rtl/pipe_slot.sv
// ---------------------------------------------------------------------------
// pipe_slot
// One {pc, data} holding register.
//   clk, rst     : clock, synchronous active-low reset (reset loads bubble)
//   load         : capture pc_in/data_in
//   load_bubble  : capture pc = 0 / data = BUBBLE_DATA (wins over load)
//   pc_in/data_in: value to capture
//   pc_out/data_out : held value
// ---------------------------------------------------------------------------
module pipe_slot #(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter logic [DATA_W-1:0] BUBBLE_DATA = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              load_bubble,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic [DATA_W-1:0] data_in,
    output logic [ADDR_W-1:0] pc_out,
    output logic [DATA_W-1:0] data_out
);
    logic [ADDR_W-1:0] pc_d,   pc_q;
    logic [DATA_W-1:0] data_d, data_q;

    // Next slot contents: bubble, new value, or hold.
    always_comb begin
        pc_d   = pc_q;
        data_d = data_q;
        if (load_bubble) begin
            pc_d   = {ADDR_W{1'b0}};
            data_d = BUBBLE_DATA;
        end else if (load) begin
            pc_d   = pc_in;
            data_d = data_in;
        end else begin
            pc_d   = pc_q;
            data_d = data_q;
        end
    end

    // Slot register with synchronous reset to the bubble value.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q   <= {ADDR_W{1'b0}};
            data_q <= BUBBLE_DATA;
        end else begin
            pc_q   <= pc_d;
            data_q <= data_d;
        end
    end

    assign pc_out   = pc_q;
    assign data_out = data_q;
endmodule

// File: rtl/pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid
// Registered pipeline-stage boundary with a two-entry skid buffer and flush.
//   clk       : clock
//   rst       : synchronous active-low reset
//   flush     : drop every held entry and any entry offered this cycle
//   bus       : handshake bundle (slave side): up_* in, dn_* out
//   occupancy : held entries, 0..2
// The main slot always drives dn_*; the skid slot only holds the entry that
// arrived in the cycle downstream stalled. up_ready, dn_valid and occupancy
// are flops loaded from the next state, so no input reaches them through
// combinational logic.
// ---------------------------------------------------------------------------
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter logic [DATA_W-1:0] BUBBLE_DATA = {DATA_W{1'b0}}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    pipe_stage_skid_if.slave      bus,
    output logic [1:0]            occupancy
);
    state_e            state_d, state_q;
    logic              up_ready_d, up_ready_q;
    logic              dn_valid_d, dn_valid_q;
    logic [1:0]        occ_d, occ_q;

    logic              in_fire_s, out_fire_s;
    logic              main_load_s, main_bubble_s, main_from_skid_s;
    logic              skid_load_s;
    logic [ADDR_W-1:0] main_pc_in_s,   main_pc_s,   skid_pc_s;
    logic [DATA_W-1:0] main_data_in_s, main_data_s, skid_data_s;

    assign in_fire_s  = bus.up_valid & up_ready_q;
    assign out_fire_s = dn_valid_q & bus.dn_ready;

    // Next-state and slot control; flush overrides every transition.
    always_comb begin
        state_d          = state_q;
        main_load_s      = 1'b0;
        main_bubble_s    = 1'b0;
        main_from_skid_s = 1'b0;
        skid_load_s      = 1'b0;
        if (flush) begin
            state_d       = ST_EMPTY;
            main_bubble_s = 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire_s) begin
                        main_load_s = 1'b1;
                        state_d     = ST_HALF;
                    end else begin
                        state_d     = ST_EMPTY;
                    end
                end
                ST_HALF: begin
                    if (in_fire_s && out_fire_s) begin
                        main_load_s = 1'b1;
                        state_d     = ST_HALF;
                    end else if (in_fire_s) begin
                        skid_load_s = 1'b1;
                        state_d     = ST_FULL;
                    end else if (out_fire_s) begin
                        main_bubble_s = 1'b1;
                        state_d       = ST_EMPTY;
                    end else begin
                        state_d     = ST_HALF;
                    end
                end
                ST_FULL: begin
                    // up_ready is low here, so only the drain can happen.
                    if (out_fire_s) begin
                        main_load_s      = 1'b1;
                        main_from_skid_s = 1'b1;
                        state_d          = ST_HALF;
                    end else begin
                        state_d          = ST_FULL;
                    end
                end
                default: begin
                    state_d       = ST_EMPTY;
                    main_bubble_s = 1'b1;
                end
            endcase
        end
    end

    // Status flags computed from the next state so they can be registered.
    always_comb begin
        up_ready_d = (state_d != ST_FULL);
        dn_valid_d = (state_d != ST_EMPTY);
        occ_d      = occ_of(state_d);
    end

    // Main slot source: skid entry on a FULL drain, otherwise upstream.
    always_comb begin
        main_pc_in_s   = bus.up_pc;
        main_data_in_s = bus.up_data;
        if (main_from_skid_s) begin
            main_pc_in_s   = skid_pc_s;
            main_data_in_s = skid_data_s;
        end else begin
            main_pc_in_s   = bus.up_pc;
            main_data_in_s = bus.up_data;
        end
    end

    // State and registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_EMPTY;
            up_ready_q <= 1'b1;
            dn_valid_q <= 1'b0;
            occ_q      <= 2'd0;
        end else begin
            state_q    <= state_d;
            up_ready_q <= up_ready_d;
            dn_valid_q <= dn_valid_d;
            occ_q      <= occ_d;
        end
    end

    pipe_slot #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .BUBBLE_DATA (BUBBLE_DATA)
    ) u_main (
        .clk         (clk),
        .rst         (rst),
        .load        (main_load_s),
        .load_bubble (main_bubble_s),
        .pc_in       (main_pc_in_s),
        .data_in     (main_data_in_s),
        .pc_out      (main_pc_s),
        .data_out    (main_data_s)
    );

    // The skid slot is cleared on flush so stale entries never linger.
    pipe_slot #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .BUBBLE_DATA (BUBBLE_DATA)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .load        (skid_load_s),
        .load_bubble (flush),
        .pc_in       (bus.up_pc),
        .data_in     (bus.up_data),
        .pc_out      (skid_pc_s),
        .data_out    (skid_data_s)
    );

    assign bus.up_ready = up_ready_q;
    assign bus.dn_valid = dn_valid_q;
    assign bus.dn_pc    = main_pc_s;
    assign bus.dn_data  = main_data_s;
    assign occupancy    = occ_q;
endmodule

// File: tb/tb_pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_skid
// Directed vector table for pipe_stage_skid, a hand-written flush/out_fire
// sequence, and a randomised run against a queue scoreboard.
// ---------------------------------------------------------------------------
module tb_pipe_stage_skid;
    localparam int          AW  = 32;
    localparam int          DW  = 32;
    localparam logic [31:0] BUB = 32'hDEAD_BEEF;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       flush = 1'b0;
    logic [1:0] occupancy;

    int n_checks = 0;
    int n_errors = 0;

    pipe_stage_skid_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    pipe_stage_skid #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .BUBBLE_DATA (BUB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .bus       (bus),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        flush;
        logic        uv;
        logic [31:0] pc;
        logic [31:0] data;
        logic        dr;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] edata;
        logic [1:0]  eocc;
        logic        erdy;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    vec_t vecs[25];
    ent_t q[$];

    function automatic vec_t mk(input logic r, input logic f, input logic uv,
                                input logic [31:0] pc, input logic [31:0] d,
                                input logic dr, input logic ev,
                                input logic [31:0] epc, input logic [31:0] ed,
                                input logic [1:0] eocc, input logic erdy);
        vec_t v;
        v.rst = r; v.flush = f; v.uv = uv; v.pc = pc; v.data = d; v.dr = dr;
        v.ev = ev; v.epc = epc; v.edata = ed; v.eocc = eocc; v.erdy = erdy;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic uv,
                         input logic [31:0] pc, input logic [31:0] d,
                         input logic dr);
        rst          = r;
        flush        = f;
        bus.up_valid = uv;
        bus.up_pc    = pc;
        bus.up_data  = d;
        bus.dn_ready = dr;
    endtask

    task automatic check_outs(input string tag, input logic ev,
                              input logic [31:0] epc, input logic [31:0] ed,
                              input logic [1:0] eocc, input logic erdy);
        check({tag, ".dn_valid"},  {63'd0, bus.dn_valid}, {63'd0, ev});
        check({tag, ".dn_pc"},     {32'd0, bus.dn_pc},    {32'd0, epc});
        check({tag, ".dn_data"},   {32'd0, bus.dn_data},  {32'd0, ed});
        check({tag, ".occupancy"}, {62'd0, occupancy},    {62'd0, eocc});
        check({tag, ".up_ready"},  {63'd0, bus.up_ready}, {63'd0, erdy});
    endtask

    initial begin
        int deliv;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

        //            rst  fl   uv   pc          data        dr   ev   epc         edata       occ   rdy
        vecs[0]  = mk(1'b0,1'b0,1'b1,32'h0000_0050,32'h5,   1'b1,1'b0,32'h0,      BUB,        2'd0,1'b1);
        vecs[1]  = mk(1'b0,1'b0,1'b1,32'h0000_0054,32'h6,   1'b1,1'b0,32'h0,      BUB,        2'd0,1'b1);
        vecs[2]  = mk(1'b1,1'b0,1'b1,32'h0000_0100,32'hA,   1'b1,1'b1,32'h100,    32'hA,      2'd1,1'b1);
        vecs[3]  = mk(1'b1,1'b0,1'b1,32'h0000_0104,32'hB,   1'b1,1'b1,32'h104,    32'hB,      2'd1,1'b1);
        vecs[4]  = mk(1'b1,1'b0,1'b1,32'h0000_0108,32'hC,   1'b1,1'b1,32'h108,    32'hC,      2'd1,1'b1);
        vecs[5]  = mk(1'b1,1'b0,1'b0,32'h0,        32'h0,   1'b1,1'b0,32'h0,      BUB,        2'd0,1'b1);
        vecs[6]  = mk(1'b1,1'b0,1'b1,32'h0000_0100,32'hA,   1'b0,1'b1,32'h100,    32'hA,      2'd1,1'b1);
        vecs[7]  = mk(1'b1,1'b0,1'b1,32'h0000_0104,32'hB,   1'b0,1'b1,32'h100,    32'hA,      2'd2,1'b0);
        vecs[8]  = mk(1'b1,1'b0,1'b1,32'h0000_01F0,32'hF0,  1'b0,1'b1,32'h100,    32'hA,      2'd2,1'b0);
        vecs[9]  = mk(1'b1,1'b0,1'b1,32'h0000_01F0,32'hF0,  1'b1,1'b1,32'h104,    32'hB,      2'd1,1'b1);
        vecs[10] = mk(1'b1,1'b0,1'b0,32'h0,        32'h0,   1'b1,1'b0,32'h0,      BUB,        2'd0,1'b1);
        vecs[11] = mk(1'b1,1'b0,1'b1,32'h0000_0110,32'hD,   1'b0,1'b1,32'h110,    32'hD,      2'd1,1'b1);
        vecs[12] = mk(1'b1,1'b0,1'b1,32'h0000_0114,32'hE,   1'b0,1'b1,32'h110,    32'hD,      2'd2,1'b0);
        vecs[13] = mk(1'b1,1'b1,1'b1,32'h0000_0200,32'hF,   1'b0,1'b0,32'h0,      BUB,        2'd0,1'b1);
        vecs[14] = mk(1'b1,1'b0,1'b0,32'h0,        32'h0,   1'b1,1'b0,32'h0,      BUB,        2'd0,1'b1);
        vecs[15] = mk(1'b1,1'b1,1'b1,32'h0000_0300,32'h30,  1'b1,1'b0,32'h0,      BUB,        2'd0,1'b1);
        vecs[16] = mk(1'b1,1'b1,1'b1,32'h0000_0304,32'h31,  1'b0,1'b0,32'h0,      BUB,        2'd0,1'b1);
        vecs[17] = mk(1'b1,1'b0,1'b1,32'h0000_0120,32'hA1,  1'b0,1'b1,32'h120,    32'hA1,     2'd1,1'b1);
        vecs[18] = mk(1'b1,1'b1,1'b0,32'h0,        32'h0,   1'b1,1'b0,32'h0,      BUB,        2'd0,1'b1);
        vecs[19] = mk(1'b1,1'b0,1'b1,32'h0000_0124,32'hA2,  1'b0,1'b1,32'h124,    32'hA2,     2'd1,1'b1);
        vecs[20] = mk(1'b1,1'b0,1'b0,32'h0,        32'h0,   1'b1,1'b0,32'h0,      BUB,        2'd0,1'b1);
        vecs[21] = mk(1'b1,1'b0,1'b1,32'h0000_0130,32'h13,  1'b0,1'b1,32'h130,    32'h13,     2'd1,1'b1);
        vecs[22] = mk(1'b1,1'b0,1'b1,32'h0000_0134,32'h14,  1'b0,1'b1,32'h130,    32'h13,     2'd2,1'b0);
        vecs[23] = mk(1'b0,1'b0,1'b1,32'h0000_0138,32'h15,  1'b1,1'b0,32'h0,      BUB,        2'd0,1'b1);
        vecs[24] = mk(1'b1,1'b0,1'b0,32'h0,        32'h0,   1'b1,1'b0,32'h0,      BUB,        2'd0,1'b1);

        // Directed table: inputs applied on the falling edge, outputs
        // compared just after the following rising edge.
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].flush, vecs[i].uv, vecs[i].pc,
                  vecs[i].data, vecs[i].dr);
            @(posedge clk);
            #1;
            check_outs($sformatf("vec%0d", i), vecs[i].ev, vecs[i].epc,
                       vecs[i].edata, vecs[i].eocc, vecs[i].erdy);
        end

        // Flush coinciding with out_fire in HALF: exactly one delivery,
        // EMPTY next cycle, new entry accepted the cycle after.
        deliv = 0;
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 32'h0000_0140, 32'h40, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1);
        #1;
        if (bus.dn_valid && bus.dn_ready && bus.dn_pc == 32'h140) deliv++;
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        #1;
        if (bus.dn_valid && bus.dn_ready && bus.dn_pc == 32'h140) deliv++;
        check_outs("fl_out.empty", 1'b0, 32'h0, BUB, 2'd0, 1'b1);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 32'h0000_0144, 32'h44, 1'b0);
        @(posedge clk);
        #1;
        check_outs("fl_out.accept", 1'b1, 32'h144, 32'h44, 2'd1, 1'b1);
        check("fl_out.deliveries", 64'(deliv), 64'd1);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        @(posedge clk);
        #1;
        check_outs("fl_out.drain", 1'b0, 32'h0, BUB, 2'd0, 1'b1);

        // Random valid/ready/flush against a queue scoreboard.
        q.delete();
        for (int c = 0; c < 10000; c++) begin
            logic        uv, dr, fl;
            logic [31:0] pc, d;
            ent_t        e;
            @(negedge clk);
            uv = ($urandom_range(0, 3) != 0);
            dr = ($urandom_range(0, 2) != 0);
            fl = ($urandom_range(0, 24) == 0);
            pc = $urandom;
            d  = $urandom;
            drive(1'b1, fl, uv, pc, d, dr);
            #1;
            if (bus.dn_valid && bus.dn_ready) begin
                if (q.size() == 0) begin
                    check("rnd.spurious_out", 64'd1, 64'd0);
                end else begin
                    check("rnd.out_pc",   {32'd0, bus.dn_pc},   {32'd0, q[0].pc});
                    check("rnd.out_data", {32'd0, bus.dn_data}, {32'd0, q[0].data});
                    void'(q.pop_front());
                end
            end
            if (fl) begin
                q.delete();
            end else if (uv && bus.up_ready) begin
                e.pc   = pc;
                e.data = d;
                q.push_back(e);
            end
            @(posedge clk);
            #1;
            check("rnd.occupancy", {62'd0, occupancy}, 64'(q.size()));
            check("rnd.up_ready", {63'd0, bus.up_ready}, {63'd0, (q.size() != 2)});
            check("rnd.dn_valid", {63'd0, bus.dn_valid}, {63'd0, (q.size() != 0)});
            if (q.size() == 0) begin
                check("rnd.bubble_pc",   {32'd0, bus.dn_pc},   64'd0);
                check("rnd.bubble_data", {32'd0, bus.dn_data}, {32'd0, BUB});
            end else begin
                check("rnd.head_pc", {32'd0, bus.dn_pc}, {32'd0, q[0].pc});
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
